imem_load_controller: RTL and testbench

Sequences the 32-word instruction memory of the single-cycle MIPS core between a boot-load phase and a run phase. In LOAD it accepts instruction words over a valid/ready stream and drives the memory write port. In RUN it releases the CPU and passes the PC through to the memory read address, flagging illegal fetch addresses. It sits between the external program loader, the CPU PC register and the instruction memory.

---
 rtl/imem_ctrl_pkg.sv | 16 +
 rtl/imem_fetch_guard.sv | 17 +
 rtl/imem_load_controller.sv | 167 ++++++++++++++++
 tb/tb_imem_load_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared types and sizing for the instruction-memory load controller.
// The state encoding and default memory geometry live here so the bench and RTL agree.
package imem_ctrl_pkg;

    localparam int IMEM_DEPTH = 32;
    localparam int IMEM_AW    = $clog2(IMEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        RUN,
        ERR
    } state_e;

endpackage : imem_ctrl_pkg

// File: rtl/imem_fetch_guard.sv
// Flags CPU fetch addresses that are misaligned or fall past the end of the
// instruction memory. Purely combinational.
module imem_fetch_guard
    import imem_ctrl_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic [31:0] pc_i,
    output logic        illegal_o
);

    // Memory spans DEPTH words of 4 bytes each; any byte address at or above this is out of range.
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

    assign illegal_o = (pc_i[1:0] != 2'b00) || (pc_i >= BYTE_LIMIT);

endmodule : imem_fetch_guard

// File: rtl/imem_load_controller.sv
// Boot-load / run sequencer for the MIPS instruction memory: streams loader words
// into the write port, then hands the PC through to the read port and releases the CPU.
module imem_load_controller
    import imem_ctrl_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic          run_req,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [31:0]   s_data,
    input  logic          s_last,
    input  logic [31:0]   pc,
    output logic [31:0]   mem_ra,
    output logic          mem_we,
    output logic [AW-1:0] mem_wa,
    output logic [31:0]   mem_wd,
    output logic          cpu_run,
    output logic          load_busy,
    output logic          load_err,
    output logic          fetch_err,
    output logic [AW:0]   word_cnt
);

    localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   word_cnt_q, word_cnt_d;
    logic          load_err_q, load_err_d;
    logic          fetch_err_q, fetch_err_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_wa_q, mem_wa_d;
    logic [31:0]   mem_wd_q, mem_wd_d;

    logic hs;
    logic start_load;
    logic overflow;
    logic illegal_pc;

    imem_fetch_guard #(
        .DEPTH (DEPTH)
    ) u_fetch_guard (
        .pc_i      (pc),
        .illegal_o (illegal_pc)
    );

    // A new load may begin from any state except while one is already in flight.
    assign start_load = load_start && (state_q inside {IDLE, RUN, ERR});
    assign hs         = s_valid && s_ready;
    assign overflow   = hs && !s_last && (word_cnt_q == LAST_IDX);

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                end else if (run_req) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (hs && s_last) begin
                    state_d = DRAIN;
                end else if (overflow) begin
                    state_d = ERR;
                end
            end
            DRAIN: state_d = RUN;
            RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                end
            end
            ERR: begin
                if (load_start) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_ready   = (state_q == LOAD);
        cpu_run   = (state_q == RUN);
        load_busy = (state_q == LOAD) || (state_q == DRAIN);
        mem_ra    = (state_q == RUN) ? pc : 32'd0;
    end

    // Write port, word counter and sticky flags
    always_comb begin
        word_cnt_d  = word_cnt_q;
        load_err_d  = load_err_q;
        fetch_err_d = fetch_err_q;
        mem_we_d    = hs;
        mem_wa_d    = mem_wa_q;
        mem_wd_d    = mem_wd_q;

        if (start_load) begin
            word_cnt_d  = '0;
            load_err_d  = 1'b0;
            fetch_err_d = 1'b0;
        end

        if (hs) begin
            mem_wa_d = word_cnt_q[AW-1:0];
            mem_wd_d = s_data;
            if (word_cnt_q != FULL_CNT) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end

        if (overflow) begin
            load_err_d = 1'b1;
        end

        // A load request in the same cycle wins, so the fresh load starts with a clean flag.
        if ((state_q == RUN) && illegal_pc && !start_load) begin
            fetch_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q  <= '0;
            load_err_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wa_q    <= '0;
            mem_wd_q    <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            load_err_q  <= load_err_d;
            fetch_err_q <= fetch_err_d;
            mem_we_q    <= mem_we_d;
            mem_wa_q    <= mem_wa_d;
            mem_wd_q    <= mem_wd_d;
        end
    end

    assign word_cnt  = word_cnt_q;
    assign load_err  = load_err_q;
    assign fetch_err = fetch_err_q;
    assign mem_we    = mem_we_q;
    assign mem_wa    = mem_wa_q;
    assign mem_wd    = mem_wd_q;

endmodule : imem_load_controller

// File: tb/tb_imem_load_controller.sv
// Directed bench for imem_load_controller: expected memory writes go into a queue
// that a negedge monitor drains; control/flag outputs are checked in-line.
module tb_imem_load_controller;
    import imem_ctrl_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    typedef struct {
        logic [AW-1:0] wa;
        logic [31:0]   wd;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          run_req = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic [31:0]   pc = '0;
    logic [31:0]   mem_ra;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [31:0]   mem_wd;
    logic          cpu_run;
    logic          load_busy;
    logic          load_err;
    logic          fetch_err;
    logic [AW:0]   word_cnt;

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    int  exp_wa    = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    always #5 clk = ~clk;

    imem_load_controller #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .run_req    (run_req),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .pc         (pc),
        .mem_ra     (mem_ra),
        .mem_we     (mem_we),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .cpu_run    (cpu_run),
        .load_busy  (load_busy),
        .load_err   (load_err),
        .fetch_err  (fetch_err),
        .word_cnt   (word_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        exp_wa     = 0;
    endtask

    task automatic pulse_run();
        run_req = 1'b1;
        step();
        run_req = 1'b0;
    endtask

    // Present one word and hold it until the controller takes it (bounded wait).
    task automatic send(input logic [31:0] data, input logic last);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        for (int i = 0; i < 20 && !done; i++) begin
            if (s_ready) begin
                exp_q.push_back('{wa: AW'(exp_wa), wd: data});
                exp_wa++;
                done = 1'b1;
            end
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!done) check("handshake_timeout_s_ready", 64'(s_ready), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"},   64'(s_ready),   64'd0);
        check({tag, "_mem_we"},    64'(mem_we),    64'd0);
        check({tag, "_mem_wa"},    64'(mem_wa),    64'd0);
        check({tag, "_mem_wd"},    64'(mem_wd),    64'd0);
        check({tag, "_cpu_run"},   64'(cpu_run),   64'd0);
        check({tag, "_load_busy"}, 64'(load_busy), 64'd0);
        check({tag, "_load_err"},  64'(load_err),  64'd0);
        check({tag, "_fetch_err"}, 64'(fetch_err), 64'd0);
        check({tag, "_word_cnt"},  64'(word_cnt),  64'd0);
        check({tag, "_mem_ra"},    64'(mem_ra),    64'd0);
    endtask

    // Write monitor: every mem_we cycle must match the oldest pending expected write.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL wr_unexpected: wa=%0d wd=0x%08h with no write pending (t=%0t)",
                         mem_wa, mem_wd, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(mem_wa), 64'(mon_e.wa));
                check("wr_data", 64'(mem_wd), 64'(mon_e.wd));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        step();

        // Three-word load, no gaps
        pulse_start();
        check("load_s_ready",   64'(s_ready),   64'd1);
        check("load_busy",      64'(load_busy), 64'd1);
        check("load_cpu_run",   64'(cpu_run),   64'd0);
        send(32'h2008_0FA0, 1'b0);
        send(32'h2009_0FA0, 1'b0);
        send(32'h0109_5020, 1'b1);
        check("drain_s_ready",  64'(s_ready),   64'd0);
        check("drain_cpu_run",  64'(cpu_run),   64'd0);
        check("drain_busy",     64'(load_busy), 64'd1);
        step();
        check("run_cpu_run",    64'(cpu_run),   64'd1);
        check("run_word_cnt",   64'(word_cnt),  64'd3);
        check("run_busy",       64'(load_busy), 64'd0);

        // Fetch guard in RUN
        pc = 32'h04;
        #1 check("ra_04", 64'(mem_ra), 64'h04);
        step();
        check("ferr_after_04", 64'(fetch_err), 64'd0);
        pc = 32'h06;
        #1 check("ra_06", 64'(mem_ra), 64'h06);
        step();
        check("ferr_after_06", 64'(fetch_err), 64'd1);
        pc = 32'h80;
        #1 check("ra_80", 64'(mem_ra), 64'h80);
        step();
        check("ferr_after_80", 64'(fetch_err), 64'd1);
        pc = 32'h00;
        step();
        check("ferr_sticky",   64'(fetch_err), 64'd1);
        check("ferr_cpu_run",  64'(cpu_run),   64'd1);

        // load_start from RUN, then a two-word reload
        pc = 32'h08;
        pulse_start();
        check("reload_cpu_run",  64'(cpu_run),   64'd0);
        check("reload_s_ready",  64'(s_ready),   64'd1);
        check("reload_ferr_clr", 64'(fetch_err), 64'd0);
        check("reload_cnt_clr",  64'(word_cnt),  64'd0);
        check("reload_mem_ra",   64'(mem_ra),    64'd0);
        send(32'hDEAD_0000, 1'b0);
        send(32'hDEAD_0001, 1'b1);
        step();
        check("reload_run",      64'(cpu_run),   64'd1);
        check("reload_word_cnt", 64'(word_cnt),  64'd2);

        // Gapped stream: valid toggles every other cycle
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send(32'h5500_0000 | 32'(i), (i == 3));
            if (i < 3) step();
        end
        step();
        check("gap_run",      64'(cpu_run),  64'd1);
        check("gap_word_cnt", 64'(word_cnt), 64'd4);

        // Overflow: a full memory without s_last
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            send(32'hA000_0000 + 32'(i), 1'b0);
        end
        check("ovf_load_err", 64'(load_err),  64'd1);
        check("ovf_s_ready",  64'(s_ready),   64'd0);
        check("ovf_cpu_run",  64'(cpu_run),   64'd0);
        check("ovf_busy",     64'(load_busy), 64'd0);
        check("ovf_word_cnt", 64'(word_cnt),  64'd32);
        pulse_run();
        check("ovf_run_ignored", 64'(cpu_run), 64'd0);
        pulse_start();
        check("ovf_clr_err",     64'(load_err), 64'd0);
        check("ovf_clr_s_ready", 64'(s_ready),  64'd1);

        // Reset in the middle of a burst, after five words
        for (int i = 0; i < 5; i++) begin
            send(32'hC000_0000 + 32'(i), 1'b0);
        end
        s_valid = 1'b1;
        s_data  = 32'hC000_0005;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midrst_no_pending_wr", 64'(exp_q.size()), 64'd0);
        s_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_idle_run",   64'(cpu_run),   64'd0);
        check("post_rst_idle_ready", 64'(s_ready),   64'd0);
        check("post_rst_idle_busy",  64'(load_busy), 64'd0);
        pc = 32'h10;
        pulse_run();
        check("post_rst_run",    64'(cpu_run), 64'd1);
        check("post_rst_mem_ra", 64'(mem_ra),  64'h10);

        step();
        check("final_no_pending_wr", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_imem_load_controller
